// File: rtl/usrt_tx_ctrl_if.sv
// Request handshakes and shift-register bus of the USRT Tx controller.
// Signal directions are named from the controller's side; the controller connects through the master modport.
interface usrt_tx_ctrl_if;
    logic        i_Req0_Valid;
    logic [7:0]  i_Req0_Data;
    logic        o_Req0_Ready;
    logic        i_Req1_Valid;
    logic [7:0]  i_Req1_Data;
    logic        o_Req1_Ready;
    logic        o_Shift_Enable;
    logic [3:0]  o_Shift_Count;
    logic [10:0] o_Shift_Data;
    logic        i_Shift_Done;

    modport master (
        input  i_Req0_Valid, i_Req0_Data, i_Req1_Valid, i_Req1_Data, i_Shift_Done,
        output o_Req0_Ready, o_Req1_Ready, o_Shift_Enable, o_Shift_Count, o_Shift_Data
    );

    modport slave (
        output i_Req0_Valid, i_Req0_Data, i_Req1_Valid, i_Req1_Data, i_Shift_Done,
        input  o_Req0_Ready, o_Req1_Ready, o_Shift_Enable, o_Shift_Count, o_Shift_Data
    );
endinterface

// File: rtl/usrt_tx_ctrl.sv
// USRT Tx controller: round-robin arbitration of two byte requesters, frame build, shift-register sequencing.
// Define USRT_TX_TIMEOUT_EN to add the done watchdog (o_Timeout); without it WAIT holds until done.
//
//   state | meaning
//   IDLE  | no frame in flight; grants a valid requester combinationally
//   START | one-cycle o_Shift_Enable pulse, frame data/count already stable
//   WAIT  | waiting for i_Shift_Done (or watchdog expiry)
//   GAP   | GAP_CYCLES idle cycles before the next grant
module usrt_tx_ctrl #(
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic       i_Pclk,
    input  logic       i_Rst_n,
    usrt_tx_ctrl_if.master bus,
    input  logic [1:0] i_Data_Bits,
    input  logic       i_Parity_En,
    input  logic       i_Parity_Odd,
    input  logic       i_Two_Stop,
    output logic       o_Busy,
    output logic       o_Grant_Id,
    output logic       o_Timeout
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_GAP   = 2'd3;

    localparam int               GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;

    logic [1:0]       r_State;
    logic [1:0]       w_Next;
    logic             r_Grant_Id;
    logic [10:0]      r_Shift_Data;
    logic [3:0]       r_Shift_Count;
    logic [GAP_W-1:0] r_Gap_Cnt;

    logic             w_Idle;
    logic             w_Grant_Any;
    logic             w_Grant_Sel;
    logic [7:0]       w_Grant_Data;
    logic [3:0]       w_Nbits;
    logic [3:0]       w_Len;
    logic [3:0]       w_Count;
    logic [10:0]      w_Frame;
    logic             w_Parity;
    logic             w_Timeout_Hit;

    // With both requesters valid the one that did not own the last frame wins.
    assign w_Idle       = (r_State == S_IDLE);
    assign w_Grant_Any  = w_Idle && (bus.i_Req0_Valid || bus.i_Req1_Valid);
    assign w_Grant_Sel  = (bus.i_Req0_Valid && bus.i_Req1_Valid) ? ~r_Grant_Id : bus.i_Req1_Valid;
    assign w_Grant_Data = w_Grant_Sel ? bus.i_Req1_Data : bus.i_Req0_Data;

    assign bus.o_Req0_Ready   = w_Grant_Any && !w_Grant_Sel;
    assign bus.o_Req1_Ready   = w_Grant_Any && w_Grant_Sel;
    assign bus.o_Shift_Enable = (r_State == S_START);
    assign bus.o_Shift_Data   = r_Shift_Data;
    assign bus.o_Shift_Count  = r_Shift_Count;
    assign o_Busy             = !w_Idle;
    assign o_Grant_Id         = r_Grant_Id;
    assign o_Timeout          = w_Timeout_Hit;

    // Frame starts all-ones so stop bits and unused upper positions need no explicit fill.
    always_comb begin
        w_Nbits  = 4'd5 + {2'b00, i_Data_Bits};
        w_Frame  = '1;
        w_Frame[0] = 1'b0;
        w_Parity = i_Parity_Odd;
        for (int i = 0; i < 8; i++) begin
            if (4'(i) < w_Nbits) begin
                w_Frame[i + 1] = w_Grant_Data[i];
                w_Parity       = w_Parity ^ w_Grant_Data[i];
            end
        end
        for (int j = 6; j <= 9; j++) begin
            if (i_Parity_En && (4'(j) == (w_Nbits + 4'd1))) begin
                w_Frame[j] = w_Parity;
            end
        end
        w_Len   = w_Nbits + {3'b000, i_Parity_En} + (i_Two_Stop ? 4'd2 : 4'd1);
        w_Count = (w_Len > 4'd10) ? 4'd10 : w_Len;
    end

    always_comb begin
        w_Next = r_State;
        case (r_State)
            S_IDLE:  if (w_Grant_Any) w_Next = S_START;
            S_START: w_Next = S_WAIT;
            S_WAIT: begin
                if (bus.i_Shift_Done) begin
                    w_Next = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
                end else if (w_Timeout_Hit) begin
                    w_Next = S_IDLE;
                end
            end
            S_GAP:   if (r_Gap_Cnt == '0) w_Next = S_IDLE;
            default: w_Next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_Pclk) begin
        if (!i_Rst_n) begin
            r_State       <= S_IDLE;
            r_Grant_Id    <= 1'b1;
            r_Shift_Data  <= 11'h7FF;
            r_Shift_Count <= 4'd0;
        end else begin
            r_State <= w_Next;
            if (w_Grant_Any) begin
                r_Grant_Id    <= w_Grant_Sel;
                r_Shift_Data  <= w_Frame;
                r_Shift_Count <= w_Count;
            end
        end
    end

    always_ff @(posedge i_Pclk) begin
        if (!i_Rst_n) begin
            r_Gap_Cnt <= '0;
        end else if ((r_State == S_WAIT) && bus.i_Shift_Done) begin
            r_Gap_Cnt <= GAP_LOAD;
        end else if ((r_State == S_GAP) && (r_Gap_Cnt != '0)) begin
            r_Gap_Cnt <= r_Gap_Cnt - 1'b1;
        end
    end

`ifdef USRT_TX_TIMEOUT_EN
    localparam int              TO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_LOAD = (TIMEOUT_CYCLES > 0) ? TO_W'(TIMEOUT_CYCLES - 1) : '0;

    logic [TO_W-1:0] r_To_Cnt;

    // Loaded while in START so the first WAIT cycle sees the full budget.
    always_ff @(posedge i_Pclk) begin
        if (!i_Rst_n) begin
            r_To_Cnt <= '0;
        end else if (r_State == S_START) begin
            r_To_Cnt <= TO_LOAD;
        end else if ((r_State == S_WAIT) && (r_To_Cnt != '0)) begin
            r_To_Cnt <= r_To_Cnt - 1'b1;
        end
    end

    assign w_Timeout_Hit = (r_State == S_WAIT) && !bus.i_Shift_Done && (r_To_Cnt == '0);
`else
    logic w_unused_timeout_cfg;
    assign w_unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
    assign w_Timeout_Hit        = 1'b0;
`endif

endmodule

// File: tb/tb_usrt_tx_ctrl.sv
// Directed self-checking bench for usrt_tx_ctrl (GAP_CYCLES=2, TIMEOUT_CYCLES=16).
module tb_usrt_tx_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] data_bits;
    logic       parity_en, parity_odd, two_stop;
    logic       busy, grant_id, timeout;
    int         n_tests = 0;
    int         n_fail  = 0;
    int         rdy_cnt;

    usrt_tx_ctrl_if bus ();

    usrt_tx_ctrl #(.GAP_CYCLES(2), .TIMEOUT_CYCLES(16)) dut (
        .i_Pclk      (clk),
        .i_Rst_n     (rst_n),
        .bus         (bus),
        .i_Data_Bits (data_bits),
        .i_Parity_En (parity_en),
        .i_Parity_Odd(parity_odd),
        .i_Two_Stop  (two_stop),
        .o_Busy      (busy),
        .o_Grant_Id  (grant_id),
        .o_Timeout   (timeout)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Done pulse in WAIT, then two GAP cycles before Busy drops.
    task automatic finish_frame(input string tag);
        bus.i_Shift_Done = 1'b1;
        step();
        bus.i_Shift_Done = 1'b0;
        chk({tag, "_gap1_busy"}, 32'(busy), 32'd1);
        step();
        chk({tag, "_gap2_busy"}, 32'(busy), 32'd1);
        step();
        chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
    endtask

    task automatic set_cfg(input logic [1:0] b, input logic pe, input logic po, input logic ts);
        data_bits = b; parity_en = pe; parity_odd = po; two_stop = ts;
    endtask

    initial begin
        bus.i_Req0_Valid = 1'b0; bus.i_Req0_Data = 8'h00;
        bus.i_Req1_Valid = 1'b0; bus.i_Req1_Data = 8'h00;
        bus.i_Shift_Done = 1'b0;
        set_cfg(2'd3, 1'b0, 1'b0, 1'b0);
        step();
        step();
        chk("rst_busy",   32'(busy), 32'd0);
        chk("rst_data",   32'(bus.o_Shift_Data), 32'h7FF);
        chk("rst_count",  32'(bus.o_Shift_Count), 32'd0);
        chk("rst_grant",  32'(grant_id), 32'd1);
        chk("rst_enable", 32'(bus.o_Shift_Enable), 32'd0);
        chk("rst_ready0", 32'(bus.o_Req0_Ready), 32'd0);
        chk("rst_timeout", 32'(timeout), 32'd0);

        // 8N1, req0 0xA5
        rst_n = 1'b1;
        bus.i_Req0_Valid = 1'b1; bus.i_Req0_Data = 8'hA5;
        #1;
        chk("a5_ready0", 32'(bus.o_Req0_Ready), 32'd1);
        chk("a5_ready1", 32'(bus.o_Req1_Ready), 32'd0);
        chk("a5_idle_en", 32'(bus.o_Shift_Enable), 32'd0);
        step();
        bus.i_Req0_Valid = 1'b0;
        chk("a5_enable", 32'(bus.o_Shift_Enable), 32'd1);
        chk("a5_ready_start", 32'(bus.o_Req0_Ready), 32'd0);
        chk("a5_data",  32'(bus.o_Shift_Data), 32'h74A);
        chk("a5_count", 32'(bus.o_Shift_Count), 32'd9);
        chk("a5_grant", 32'(grant_id), 32'd0);
        set_cfg(2'd0, 1'b1, 1'b1, 1'b1);
        step();
        chk("a5_wait_en",   32'(bus.o_Shift_Enable), 32'd0);
        chk("a5_wait_busy", 32'(busy), 32'd1);
        chk("a5_cfg_hold",  32'(bus.o_Shift_Data), 32'h74A);
        finish_frame("a5");
        chk("a5_data_held", 32'(bus.o_Shift_Data), 32'h74A);

        // 7E1, req1 0x41
        set_cfg(2'd2, 1'b1, 1'b0, 1'b0);
        bus.i_Req1_Valid = 1'b1; bus.i_Req1_Data = 8'h41;
        #1;
        chk("41_ready1", 32'(bus.o_Req1_Ready), 32'd1);
        chk("41_ready0", 32'(bus.o_Req0_Ready), 32'd0);
        step();
        bus.i_Req1_Valid = 1'b0;
        chk("41_data",  32'(bus.o_Shift_Data), 32'h682);
        chk("41_count", 32'(bus.o_Shift_Count), 32'd9);
        chk("41_grant", 32'(grant_id), 32'd1);
        step();
        finish_frame("41");

        // 8O2, req0 0xFF: second stop bit dropped
        set_cfg(2'd3, 1'b1, 1'b1, 1'b1);
        bus.i_Req0_Valid = 1'b1; bus.i_Req0_Data = 8'hFF;
        step();
        bus.i_Req0_Valid = 1'b0;
        chk("ff_data",  32'(bus.o_Shift_Data), 32'h7FE);
        chk("ff_count", 32'(bus.o_Shift_Count), 32'd10);
        step();
        finish_frame("ff");

        // 5E1, req1 0xE3: upper bits must not enter parity
        set_cfg(2'd0, 1'b1, 1'b0, 1'b0);
        bus.i_Req1_Valid = 1'b1; bus.i_Req1_Data = 8'hE3;
        step();
        bus.i_Req1_Valid = 1'b0;
        chk("e3_data",  32'(bus.o_Shift_Data), 32'h786);
        chk("e3_count", 32'(bus.o_Shift_Count), 32'd7);
        step();
        finish_frame("e3");

        // Both requesters valid continuously after reset: 0,1,0,1
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        set_cfg(2'd3, 1'b0, 1'b0, 1'b0);
        bus.i_Req0_Valid = 1'b1; bus.i_Req0_Data = 8'h11;
        bus.i_Req1_Valid = 1'b1; bus.i_Req1_Data = 8'h22;
        #1;
        for (int k = 0; k < 4; k++) begin
            chk("rr_ready0", 32'(bus.o_Req0_Ready), 32'((k % 2) == 0));
            chk("rr_ready1", 32'(bus.o_Req1_Ready), 32'((k % 2) == 1));
            step();
            rdy_cnt = 32'(bus.o_Req0_Ready) + 32'(bus.o_Req1_Ready);
            chk("rr_grant", 32'(grant_id), 32'(k % 2));
            chk("rr_data", 32'(bus.o_Shift_Data), ((k % 2) == 0) ? 32'h622 : 32'h644);
            step();
            rdy_cnt = rdy_cnt + 32'(bus.o_Req0_Ready) + 32'(bus.o_Req1_Ready);
            chk("rr_extra_ready", 32'(rdy_cnt), 32'd0);
            finish_frame("rr");
        end
        bus.i_Req0_Valid = 1'b0;
        bus.i_Req1_Valid = 1'b0;
        step();

        // Reset in WAIT, late done ignored
        bus.i_Req0_Valid = 1'b1; bus.i_Req0_Data = 8'h3C;
        step();
        bus.i_Req0_Valid = 1'b0;
        step();
        chk("rw_in_wait", 32'(busy), 32'd1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("rw_busy",  32'(busy), 32'd0);
        chk("rw_data",  32'(bus.o_Shift_Data), 32'h7FF);
        chk("rw_grant", 32'(grant_id), 32'd1);
        bus.i_Shift_Done = 1'b1;
        step();
        bus.i_Shift_Done = 1'b0;
        chk("rw_done_busy", 32'(busy), 32'd0);
        chk("rw_done_en",   32'(bus.o_Shift_Enable), 32'd0);
        chk("rw_done_rdy",  32'(bus.o_Req0_Ready | bus.o_Req1_Ready), 32'd0);
        step();
        chk("rw_idle_busy", 32'(busy), 32'd0);
        chk("rw_idle_en",   32'(bus.o_Shift_Enable), 32'd0);
        bus.i_Req1_Valid = 1'b1; bus.i_Req1_Data = 8'h5A;
        #1;
        chk("rw_new_ready1", 32'(bus.o_Req1_Ready), 32'd1);
        step();
        bus.i_Req1_Valid = 1'b0;
        chk("rw_new_en",   32'(bus.o_Shift_Enable), 32'd1);
        chk("rw_new_data", 32'(bus.o_Shift_Data), 32'h6B4);
        step();
        finish_frame("rw");

        // Watchdog
        bus.i_Req0_Valid = 1'b1; bus.i_Req0_Data = 8'h00;
        step();
        bus.i_Req0_Valid = 1'b0;
        chk("to_data", 32'(bus.o_Shift_Data), 32'h600);
        step();
        chk("to_wait1", 32'(timeout), 32'd0);
`ifdef USRT_TX_TIMEOUT_EN
        repeat (14) step();
        chk("to_wait15", 32'(timeout), 32'd0);
        step();
        chk("to_wait16", 32'(timeout), 32'd1);
        chk("to_wait16_busy", 32'(busy), 32'd1);
        step();
        chk("to_idle_busy", 32'(busy), 32'd0);
        chk("to_idle_to",   32'(timeout), 32'd0);
        bus.i_Req0_Valid = 1'b1; bus.i_Req0_Data = 8'h81;
        #1;
        chk("to_next_ready0", 32'(bus.o_Req0_Ready), 32'd1);
        step();
        bus.i_Req0_Valid = 1'b0;
        chk("to_next_en", 32'(bus.o_Shift_Enable), 32'd1);
        step();
        finish_frame("to_next");
`else
        repeat (20) step();
        chk("to_none",      32'(timeout), 32'd0);
        chk("to_none_busy", 32'(busy), 32'd1);
        finish_frame("to_none");
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
